decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
- Parametrised successor to the single-register decode/issue pipeline latch.
- Sits between fetch and issue. Extracts the per-instruction fields from the fetched word and latches them, together with the control bundle produced by the Control block, into a DEPTH-entry in-order FIFO.
- Replaces the stall-hold register with a valid/ready handshake on both sides. Adds zero-extended immediates, a flush input and an occupancy count.

Parameters:
- DEPTH, 4, number of buffered decoded instructions; power of 2, minimum 2.
- CTRL_W, 16, width of the opaque control bundle from Control (aluop, shiftop, readmem, writemem, writereg, writeov, selwsource, selimregb, selalushift, unsig, ...).
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- flush  input  1  synchronous discard of all entries (branch mispredict / exception)
- if_id_valid  input  1  fetch presents an instruction
- id_if_ready  output  1  queue can accept this cycle
- if_id_instruc  input  32  instruction word
- if_id_nextpc  input  32  PC+4 of the instruction
- ctl_id_bundle  input  CTRL_W  control bundle decoded from if_id_instruc
- ctl_id_selregdest  input  1  1 = three-operand form (rd), 0 = rt destination
- ctl_id_zeroext  input  1  1 = zero-extend the immediate (andi/ori/xori), 0 = sign-extend
- id_iss_valid  output  1  head entry is valid
- iss_id_ready  input  1  issue accepts the head entry
- id_iss_bundle  output  CTRL_W  head control bundle
- id_iss_regdest  output  5  head destination register
- id_iss_imedext  output  32  head extended immediate
- id_iss_op  output  6  head instr[31:26]
- id_iss_funct  output  6  head instr[5:0]
- id_iss_addra  output  5  head instr[25:21]
- id_iss_addrb  output  5  head instr[20:16]
- id_iss_nextpc  output  32  head PC+4
- id_count  output  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Reset (reset=0, asynchronous): write/read pointers 0, count 0, all storage 0. id_iss_valid=0, id_if_ready=1, all payload outputs 0. Reset asserted mid-stream drops every entry immediately.
- id_if_ready = (count < DEPTH). Purely a function of registered state; no combinational path from iss_id_ready.
- Enqueue when if_id_valid & id_if_ready & ~flush. The entry is computed at enqueue time:
  - regdest = selregdest ? instr[15:11] : instr[20:16].
  - imedext = zeroext ? {16'h0000, instr[15:0]} : {{16{instr[15]}}, instr[15:0]}.
  - op, funct, addra, addrb, nextpc and bundle are copied directly.
- Dequeue when id_iss_valid & iss_id_ready & ~flush. Read pointer advances, wrapping modulo DEPTH.
- id_iss_valid = (count != 0).
- When id_iss_valid=0, every payload output is forced to 0 (a bubble identical to the reset value). When id_iss_valid=1, outputs show the head slot.
- Latency: an instruction enqueued at edge N appears at the head no earlier than after edge N. There is no fetch-to-issue bypass.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. This is legal at any occupancy 1..DEPTH-1.
  - Full: ready=0, so only a dequeue can occur. Count becomes DEPTH-1, and ready=1 in the following cycle.
  - Empty: valid=0, so no dequeue can occur. An enqueue makes count 1.
- Flush at edge: pointers and count become 0 at the next edge. Any enqueue or dequeue requested in that same cycle is ignored. Storage contents need not be cleared, but outputs read 0 because valid=0.
- Holding data: fetch must keep instruc/nextpc/ctl stable while if_id_valid=1 & id_if_ready=0. Issue sees the head held stable while valid=1 & iss_id_ready=0.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Count is tracked separately so full and empty are unambiguous.

Test Plan:
- Reset, then enqueue 0x2128FFFC (addi $8,$9,-4; selregdest=0, zeroext=0) with nextpc=0x00400004 -> one cycle later id_iss_valid=1, regdest=8, imedext=0xFFFFFFFC, op=0x08, addra=9, addrb=8, nextpc=0x00400004, id_count=1.
- Enqueue 0x3528FFFC (ori, zeroext=1) -> imedext=0x0000FFFC. Enqueue 0x012A4020 (add $8,$9,$10; selregdest=1) -> regdest=8, funct=0x20, addrb=10.
- DEPTH=4, iss_id_ready=0, 5 back-to-back valid enqueues -> id_count reaches 4, id_if_ready=0 after the 4th. The 5th is not accepted; raising iss_id_ready for 1 cycle lets the 5th enter, and order is preserved 1..5.
- Continuous streaming, if_id_valid=1 and iss_id_ready=1 for 20 cycles with incrementing nextpc -> count holds at 1, one instruction retires per cycle, no loss or duplication across pointer wrap.
- Fill 3 entries, assert flush together with if_id_valid=1 and iss_id_ready=1 -> next cycle count=0, id_iss_valid=0, all payload outputs 0, the flushed-cycle instruction is dropped.
- Drive reset low asynchronously mid-stream with count=2 -> outputs 0 and id_if_ready=1 before the next clock edge. After release, the first enqueue appears at head with count=1.

Source files
------------

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - in-order decoded-instruction FIFO between fetch and issue
//
// Purpose: extracts per-instruction fields from the fetched word, merges them
// with the control bundle and buffers up to DEPTH entries with valid/ready
// handshakes on both sides.
//
// Ports:
//   clock, reset (async, active-low), flush (sync discard of all entries)
//   fetch side : if_id_valid, id_if_ready, if_id_instruc, if_id_nextpc,
//                ctl_id_bundle, ctl_id_selregdest, ctl_id_zeroext
//   issue side : id_iss_valid, iss_id_ready, id_iss_bundle, id_iss_regdest,
//                id_iss_imedext, id_iss_op, id_iss_funct, id_iss_addra,
//                id_iss_addrb, id_iss_nextpc
//   status     : id_count (occupancy 0..DEPTH)
module decode_queue #(
  parameter int DEPTH  = 4,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              if_id_valid,
  output logic              id_if_ready,
  input  logic [31:0]       if_id_instruc,
  input  logic [31:0]       if_id_nextpc,
  input  logic [CTRL_W-1:0] ctl_id_bundle,
  input  logic              ctl_id_selregdest,
  input  logic              ctl_id_zeroext,
  output logic              id_iss_valid,
  input  logic              iss_id_ready,
  output logic [CTRL_W-1:0] id_iss_bundle,
  output logic [4:0]        id_iss_regdest,
  output logic [31:0]       id_iss_imedext,
  output logic [5:0]        id_iss_op,
  output logic [5:0]        id_iss_funct,
  output logic [4:0]        id_iss_addra,
  output logic [4:0]        id_iss_addrb,
  output logic [31:0]       id_iss_nextpc,
  output logic [CNT_W-1:0]  id_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [CTRL_W-1:0] bundle_q  [DEPTH];
  logic [4:0]        regdest_q [DEPTH];
  logic [31:0]       imedext_q [DEPTH];
  logic [5:0]        op_q      [DEPTH];
  logic [5:0]        funct_q   [DEPTH];
  logic [4:0]        addra_q   [DEPTH];
  logic [4:0]        addrb_q   [DEPTH];
  logic [31:0]       nextpc_q  [DEPTH];

  logic        enq;
  logic        deq;
  logic [4:0]  new_regdest;
  logic [31:0] new_imedext;

  // Handshake status comes only from registered count, so there is no
  // combinational path from iss_id_ready to id_if_ready.
  assign id_if_ready  = (count_q < FULL_CNT);
  assign id_iss_valid = (count_q != '0);
  assign id_count     = count_q;

  // Flush overrides both transfers in the same cycle.
  assign enq = if_id_valid & id_if_ready & ~flush;
  assign deq = id_iss_valid & iss_id_ready & ~flush;

  assign new_regdest = ctl_id_selregdest ? if_id_instruc[15:11] : if_id_instruc[20:16];
  assign new_imedext = ctl_id_zeroext ? {16'h0000, if_id_instruc[15:0]}
                                      : {{16{if_id_instruc[15]}}, if_id_instruc[15:0]};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        bundle_q[i]  <= '0;
        regdest_q[i] <= '0;
        imedext_q[i] <= '0;
        op_q[i]      <= '0;
        funct_q[i]   <= '0;
        addra_q[i]   <= '0;
        addrb_q[i]   <= '0;
        nextpc_q[i]  <= '0;
      end
    end else if (enq) begin
      bundle_q[wr_ptr_q]  <= ctl_id_bundle;
      regdest_q[wr_ptr_q] <= new_regdest;
      imedext_q[wr_ptr_q] <= new_imedext;
      op_q[wr_ptr_q]      <= if_id_instruc[31:26];
      funct_q[wr_ptr_q]   <= if_id_instruc[5:0];
      addra_q[wr_ptr_q]   <= if_id_instruc[25:21];
      addrb_q[wr_ptr_q]   <= if_id_instruc[20:16];
      nextpc_q[wr_ptr_q]  <= if_id_nextpc;
    end
  end

  // An empty queue presents a bubble equal to the reset value; stale slot
  // contents after a flush are never visible.
  assign id_iss_bundle  = id_iss_valid ? bundle_q[rd_ptr_q]  : '0;
  assign id_iss_regdest = id_iss_valid ? regdest_q[rd_ptr_q] : '0;
  assign id_iss_imedext = id_iss_valid ? imedext_q[rd_ptr_q] : '0;
  assign id_iss_op      = id_iss_valid ? op_q[rd_ptr_q]      : '0;
  assign id_iss_funct   = id_iss_valid ? funct_q[rd_ptr_q]   : '0;
  assign id_iss_addra   = id_iss_valid ? addra_q[rd_ptr_q]   : '0;
  assign id_iss_addrb   = id_iss_valid ? addrb_q[rd_ptr_q]   : '0;
  assign id_iss_nextpc  = id_iss_valid ? nextpc_q[rd_ptr_q]  : '0;

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - scoreboard testbench for decode_queue
module tb_decode_queue;

  localparam int DEPTH  = 4;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 3;

  logic              clock;
  logic              reset;
  logic              flush;
  logic              if_id_valid;
  logic              id_if_ready;
  logic [31:0]       if_id_instruc;
  logic [31:0]       if_id_nextpc;
  logic [CTRL_W-1:0] ctl_id_bundle;
  logic              ctl_id_selregdest;
  logic              ctl_id_zeroext;
  logic              id_iss_valid;
  logic              iss_id_ready;
  logic [CTRL_W-1:0] id_iss_bundle;
  logic [4:0]        id_iss_regdest;
  logic [31:0]       id_iss_imedext;
  logic [5:0]        id_iss_op;
  logic [5:0]        id_iss_funct;
  logic [4:0]        id_iss_addra;
  logic [4:0]        id_iss_addrb;
  logic [31:0]       id_iss_nextpc;
  logic [CNT_W-1:0]  id_count;

  decode_queue #(.DEPTH(DEPTH), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .if_id_valid(if_id_valid), .id_if_ready(id_if_ready),
    .if_id_instruc(if_id_instruc), .if_id_nextpc(if_id_nextpc),
    .ctl_id_bundle(ctl_id_bundle), .ctl_id_selregdest(ctl_id_selregdest),
    .ctl_id_zeroext(ctl_id_zeroext),
    .id_iss_valid(id_iss_valid), .iss_id_ready(iss_id_ready),
    .id_iss_bundle(id_iss_bundle), .id_iss_regdest(id_iss_regdest),
    .id_iss_imedext(id_iss_imedext), .id_iss_op(id_iss_op),
    .id_iss_funct(id_iss_funct), .id_iss_addra(id_iss_addra),
    .id_iss_addrb(id_iss_addrb), .id_iss_nextpc(id_iss_nextpc),
    .id_count(id_count)
  );

  typedef struct packed {
    logic [CTRL_W-1:0] bundle;
    logic [4:0]        regdest;
    logic [31:0]       imedext;
    logic [5:0]        op;
    logic [5:0]        funct;
    logic [4:0]        addra;
    logic [4:0]        addrb;
    logic [31:0]       nextpc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int n_pop = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic srd, input logic zx,
                                 input logic [CTRL_W-1:0] b);
    exp_t e;
    e.bundle  = b;
    e.regdest = srd ? ins[15:11] : ins[20:16];
    e.imedext = zx ? {16'h0000, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
    e.op      = ins[31:26];
    e.funct   = ins[5:0];
    e.addra   = ins[25:21];
    e.addrb   = ins[20:16];
    e.nextpc  = pc;
    return e;
  endfunction

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: samples on the falling edge what the next rising edge will do.
  always @(negedge clock) begin
    if (!reset) begin
      sb.delete();
    end else begin
      chk("count", 32'(id_count), 32'(sb.size()));
      chk("valid", 32'(id_iss_valid), 32'(sb.size() != 0));
      chk("ready", 32'(id_if_ready), 32'(sb.size() < DEPTH));
      if (!id_iss_valid) begin
        chk("bub_bundle", 32'(id_iss_bundle), 32'h0);
        chk("bub_fields", {5'b0, id_iss_regdest, id_iss_op, id_iss_funct,
                           id_iss_addra, id_iss_addrb}, 32'h0);
        chk("bub_imm", id_iss_imedext, 32'h0);
        chk("bub_pc", id_iss_nextpc, 32'h0);
      end
      if (flush) begin
        sb.delete();
      end else begin
        if (id_iss_valid && iss_id_ready) begin
          if (sb.size() == 0) begin
            chk("underflow", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            n_pop++;
            chk("sb_bundle", 32'(id_iss_bundle), 32'(e.bundle));
            chk("sb_regdest", 32'(id_iss_regdest), 32'(e.regdest));
            chk("sb_imedext", id_iss_imedext, e.imedext);
            chk("sb_opfn", {20'b0, id_iss_op, id_iss_funct}, {20'b0, e.op, e.funct});
            chk("sb_addr", {22'b0, id_iss_addra, id_iss_addrb}, {22'b0, e.addra, e.addrb});
            chk("sb_nextpc", id_iss_nextpc, e.nextpc);
          end
        end
        if (if_id_valid && id_if_ready)
          sb.push_back(model(if_id_instruc, if_id_nextpc, ctl_id_selregdest,
                             ctl_id_zeroext, ctl_id_bundle));
      end
    end
  end

  task automatic put(input logic [31:0] ins, input logic [31:0] pc,
                     input logic srd, input logic zx);
    if_id_valid       = 1'b1;
    if_id_instruc     = ins;
    if_id_nextpc      = pc;
    ctl_id_selregdest = srd;
    ctl_id_zeroext    = zx;
    ctl_id_bundle     = CTRL_W'($urandom);
  endtask

  task automatic idle();
    if_id_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    iss_id_ready = 1'b1;
    for (int k = 0; k < 20 && id_count != 0; k++) step();
    chk("drain", 32'(id_count), 32'h0);
    iss_id_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int p0;
    reset = 1'b0; flush = 1'b0; iss_id_ready = 1'b0;
    if_id_valid = 1'b0; if_id_instruc = '0; if_id_nextpc = '0;
    ctl_id_bundle = '0; ctl_id_selregdest = 1'b0; ctl_id_zeroext = 1'b0;
    #2;
    chk("rst_valid", 32'(id_iss_valid), 32'h0);
    chk("rst_ready", 32'(id_if_ready), 32'h1);
    chk("rst_count", 32'(id_count), 32'h0);
    chk("rst_imm", id_iss_imedext, 32'h0);
    #11 reset = 1'b1;

    // Directed field extraction
    step();
    put(32'h2128FFFC, 32'h00400004, 1'b0, 1'b0);
    step();
    chk("addi_valid", 32'(id_iss_valid), 32'h1);
    chk("addi_regdest", 32'(id_iss_regdest), 32'd8);
    chk("addi_imm", id_iss_imedext, 32'hFFFFFFFC);
    chk("addi_op", 32'(id_iss_op), 32'h08);
    chk("addi_addra", 32'(id_iss_addra), 32'd9);
    chk("addi_addrb", 32'(id_iss_addrb), 32'd8);
    chk("addi_pc", id_iss_nextpc, 32'h00400004);
    chk("addi_count", 32'(id_count), 32'h1);
    put(32'h3528FFFC, 32'h00400008, 1'b0, 1'b1);
    step();
    put(32'h012A4020, 32'h0040000C, 1'b1, 1'b0);
    step();
    idle();
    iss_id_ready = 1'b1;
    step();
    chk("ori_imm", id_iss_imedext, 32'h0000FFFC);
    chk("ori_op", 32'(id_iss_op), 32'h0D);
    step();
    chk("add_regdest", 32'(id_iss_regdest), 32'd8);
    chk("add_funct", 32'(id_iss_funct), 32'h20);
    chk("add_addrb", 32'(id_iss_addrb), 32'd10);
    drain();

    // Fill to full with issue stalled; 5th waits
    for (int i = 1; i <= 4; i++) begin
      put(32'h20000000 | 32'(i), 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
      step();
    end
    chk("full_count", 32'(id_count), 32'd4);
    chk("full_ready", 32'(id_if_ready), 32'h0);
    put(32'h20000005, 32'h1014, 1'b0, 1'b0);
    step();
    chk("full_hold", 32'(id_count), 32'd4);
    iss_id_ready = 1'b1;
    step();
    iss_id_ready = 1'b0;
    chk("full_deq", 32'(id_count), 32'd3);
    chk("full_ready2", 32'(id_if_ready), 32'h1);
    chk("full_head", id_iss_nextpc, 32'h1008);
    step();
    idle();
    chk("full_fifth", 32'(id_count), 32'd4);
    drain();

    // Streaming across pointer wrap
    p0 = n_pop;
    iss_id_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      put($urandom, 32'h8000 + 32'(4 * i), 1'($urandom), 1'($urandom));
      step();
      chk("stream_cnt", 32'(id_count), 32'h1);
    end
    idle();
    step();
    chk("stream_pop", 32'(n_pop - p0), 32'd20);
    chk("stream_empty", 32'(id_count), 32'h0);
    iss_id_ready = 1'b0;

    // Flush with simultaneous enqueue/dequeue request
    for (int i = 0; i < 3; i++) begin
      put($urandom, 32'hA000 + 32'(4 * i), 1'b0, 1'b0);
      step();
    end
    put(32'h2128FFFC, 32'hA00C, 1'b0, 1'b0);
    iss_id_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    iss_id_ready = 1'b0;
    chk("flush_count", 32'(id_count), 32'h0);
    chk("flush_valid", 32'(id_iss_valid), 32'h0);
    chk("flush_pc", id_iss_nextpc, 32'h0);
    chk("flush_imm", id_iss_imedext, 32'h0);
    step();
    chk("flush_drop", 32'(id_count), 32'h0);

    // Asynchronous reset mid-stream
    put($urandom, 32'hB000, 1'b0, 1'b0);
    step();
    put($urandom, 32'hB004, 1'b0, 1'b0);
    step();
    idle();
    chk("pre_rst_count", 32'(id_count), 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("arst_count", 32'(id_count), 32'h0);
    chk("arst_valid", 32'(id_iss_valid), 32'h0);
    chk("arst_ready", 32'(id_if_ready), 32'h1);
    chk("arst_pc", id_iss_nextpc, 32'h0);
    @(posedge clock);
    #3 reset = 1'b1;
    step();
    put(32'h3528FFFC, 32'hC004, 1'b0, 1'b1);
    step();
    idle();
    chk("post_count", 32'(id_count), 32'h1);
    chk("post_pc", id_iss_nextpc, 32'hC004);
    chk("post_imm", id_iss_imedext, 32'h0000FFFC);
    drain();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
